fft_stage_feeder: RTL and testbench

- Upstream neighbour of the iterative fixed-point butterfly.
- Collects one frame of N complex fixed-point samples over a val/rdy stream into a local buffer.
- Issues the N/2 butterfly operand sets (a, b, w) for one radix-2 FFT stage, one set per accepted transfer.
- Its output bundle connects port-for-port to the butterfly's recv side.

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_stage_feeder_addr_gen.sv | 33 +++
 rtl/fft_stage_feeder.sv | 106 ++++++++++
 tb/tb_fft_stage_feeder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type and counter-width helper for the FFT stage feeder
package fft_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Counter width for a range of 'count' values, never narrower than one bit.
  function automatic int cnt_width(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/fft_stage_feeder_addr_gen.sv
// rtl/fft_stage_feeder_addr_gen.sv - maps pair index k to operand and twiddle indices for one radix-2 stage
module fft_stage_feeder_addr_gen
  import fft_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int STAGE     = 0,
  localparam int CW       = cnt_width(N_SAMPLES),
  localparam int KW       = cnt_width(N_SAMPLES / 2)
) (
  input  logic [KW-1:0] k,
  output logic [CW-1:0] a_idx,
  output logic [CW-1:0] b_idx,
  output logic [KW-1:0] tw_idx
);

  localparam int H        = 1 << STAGE;
  localparam int TW_SHIFT = $clog2(N_SAMPLES) - 1 - STAGE;

  logic [CW-1:0] k_ext;
  logic [CW-1:0] group;
  logic [CW-1:0] pos;

  // pos < h, so group*2h + pos and the twiddle stride are pure shifts.
  always_comb begin
    k_ext  = CW'(k);
    group  = k_ext >> STAGE;
    pos    = k_ext & CW'(H - 1);
    a_idx  = (group << (STAGE + 1)) + pos;
    b_idx  = a_idx + CW'(H);
    tw_idx = KW'(pos << TW_SHIFT);
  end

endmodule

// File: rtl/fft_stage_feeder.sv
// rtl/fft_stage_feeder.sv - buffers one frame of complex samples and issues the butterfly operand sets of one FFT stage
module fft_stage_feeder
  import fft_pkg::*;
#(
  parameter int n         = 32,
  parameter int d         = 16,
  parameter int N_SAMPLES = 8,
  parameter int STAGE     = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       recv_val,
  output logic                       recv_rdy,
  input  logic [n-1:0]               recv_r,
  input  logic [n-1:0]               recv_c,
  input  logic [n*N_SAMPLES/2-1:0]   wr_table,
  input  logic [n*N_SAMPLES/2-1:0]   wc_table,
  output logic                       send_val,
  input  logic                       send_rdy,
  output logic [n-1:0]               ar,
  output logic [n-1:0]               ac,
  output logic [n-1:0]               br,
  output logic [n-1:0]               bc,
  output logic [n-1:0]               wr,
  output logic [n-1:0]               wc
);

  localparam int PAIRS = N_SAMPLES / 2;
  localparam int CW    = cnt_width(N_SAMPLES);
  localparam int KW    = cnt_width(PAIRS);

  if (d > n || STAGE < 0 || (1 << STAGE) > PAIRS) begin : g_param_check
    $error("fft_stage_feeder: d must not exceed n and STAGE must lie in 0..log2(N_SAMPLES)-1");
  end

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic [KW-1:0]   k;
  logic [2*n-1:0]  sample_buf [N_SAMPLES];
  logic            recv_fire;
  logic            send_fire;
  logic [CW-1:0]   a_idx;
  logic [CW-1:0]   b_idx;
  logic [KW-1:0]   tw_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    case (state)
      LOAD: begin
        recv_rdy = 1'b1;
        if (recv_val && count == CW'(N_SAMPLES - 1)) state_nxt = ISSUE;
      end
      ISSUE: begin
        send_val = 1'b1;
        if (send_rdy && k == KW'(PAIRS - 1)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign recv_fire = recv_val & recv_rdy;
  assign send_fire = send_val & send_rdy;

  // Single-bank buffer: loading and issuing are mutually exclusive by state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      k     <= '0;
      for (int i = 0; i < N_SAMPLES; i++) sample_buf[i] <= '0;
    end else begin
      if (recv_fire) begin
        sample_buf[count] <= {recv_r, recv_c};
        count             <= (count == CW'(N_SAMPLES - 1)) ? '0 : count + CW'(1);
      end
      if (send_fire) begin
        k <= (k == KW'(PAIRS - 1)) ? '0 : k + KW'(1);
      end
    end
  end

  fft_stage_feeder_addr_gen #(
    .N_SAMPLES (N_SAMPLES),
    .STAGE     (STAGE)
  ) u_addr_gen (
    .k      (k),
    .a_idx  (a_idx),
    .b_idx  (b_idx),
    .tw_idx (tw_idx)
  );

  assign ar = sample_buf[a_idx][2*n-1:n];
  assign ac = sample_buf[a_idx][n-1:0];
  assign br = sample_buf[b_idx][2*n-1:n];
  assign bc = sample_buf[b_idx][n-1:0];
  assign wr = wr_table[int'(tw_idx)*n +: n];
  assign wc = wc_table[int'(tw_idx)*n +: n];

endmodule

// File: tb/tb_fft_stage_feeder.sv
// tb/tb_fft_stage_feeder.sv - scoreboard bench running STAGE 0, 1 and 2 feeders side by side on one stimulus
module tb_fft_stage_feeder;

  localparam int n    = 32;
  localparam int NS   = 8;
  localparam int NP   = NS / 2;
  localparam int NDUT = 3;

  typedef struct packed {
    logic [31:0] ar;
    logic [31:0] ac;
    logic [31:0] br;
    logic [31:0] bc;
    logic [31:0] wr;
    logic [31:0] wc;
  } pair_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            recv_val = 1'b0;
  logic            send_rdy = 1'b0;
  logic [n-1:0]    recv_r = '0;
  logic [n-1:0]    recv_c = '0;
  logic [n*NP-1:0] wr_table = '0;
  logic [n*NP-1:0] wc_table = '0;

  logic            recv_rdy_o [NDUT];
  logic            send_val_o [NDUT];
  logic [n-1:0]    ar_o [NDUT];
  logic [n-1:0]    ac_o [NDUT];
  logic [n-1:0]    br_o [NDUT];
  logic [n-1:0]    bc_o [NDUT];
  logic [n-1:0]    wr_o [NDUT];
  logic [n-1:0]    wc_o [NDUT];

  int checks = 0;
  int failures = 0;

  pair_t exp_q [NDUT][$];

  int a_tab  [NDUT][NP] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
  int b_tab  [NDUT][NP] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
  int tw_tab [NDUT][NP] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fft_stage_feeder #(
      .n         (n),
      .d         (16),
      .N_SAMPLES (NS),
      .STAGE     (g)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy_o[g]),
      .recv_r   (recv_r),
      .recv_c   (recv_c),
      .wr_table (wr_table),
      .wc_table (wc_table),
      .send_val (send_val_o[g]),
      .send_rdy (send_rdy),
      .ar       (ar_o[g]),
      .ac       (ac_o[g]),
      .br       (br_o[g]),
      .bc       (bc_o[g]),
      .wr       (wr_o[g]),
      .wc       (wc_o[g])
    );
  end

  function automatic pair_t observed(input int s);
    pair_t p;
    p.ar = ar_o[s]; p.ac = ac_o[s]; p.br = br_o[s];
    p.bc = bc_o[s]; p.wr = wr_o[s]; p.wc = wc_o[s];
    return p;
  endfunction

  task automatic push_expected(input int base);
    logic [31:0] sr [NS];
    logic [31:0] sc [NS];
    pair_t p;
    for (int i = 0; i < NS; i++) begin
      sr[i] = 32'(i + 1 + base) << 16;
      sc[i] = 32'd0 - sr[i];
    end
    for (int s = 0; s < NDUT; s++) begin
      for (int k = 0; k < NP; k++) begin
        p.ar = sr[a_tab[s][k]];
        p.ac = sc[a_tab[s][k]];
        p.br = sr[b_tab[s][k]];
        p.bc = sc[b_tab[s][k]];
        p.wr = 32'h100 + 32'(tw_tab[s][k]);
        p.wc = 32'h200 + 32'(tw_tab[s][k]);
        exp_q[s].push_back(p);
      end
    end
  endtask

  task automatic check_idle(input string name);
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      if (send_val_o[s] !== 1'b0 || recv_rdy_o[s] !== 1'b1) begin
        failures++;
        $display("FAIL %s stage%0d send_val=%b recv_rdy=%b expected send_val=0 recv_rdy=1",
                 name, s, send_val_o[s], recv_rdy_o[s]);
      end
    end
  endtask

  task automatic push_sample(input logic [31:0] r, input logic [31:0] c);
    int t = 0;
    recv_val = 1'b1;
    recv_r   = r;
    recv_c   = c;
    while (recv_rdy_o[0] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      failures++;
      $display("FAIL recv_timeout recv_rdy=%b expected 1 within 50 cycles", recv_rdy_o[0]);
    end
    @(negedge clk);
    recv_val = 1'b0;
  endtask

  task automatic load_frame(input int base, input int gap);
    logic [31:0] v;
    push_expected(base);
    for (int i = 0; i < NS; i++) begin
      v = 32'(i + 1 + base) << 16;
      push_sample(v, 32'd0 - v);
      if (i == 3) check_idle("mid_load");
      if (i < NS - 1) begin
        for (int g = 0; g < gap; g++) begin
          recv_r = 32'hDEAD_BEEF;
          recv_c = 32'h0BAD_F00D;
          @(negedge clk);
        end
      end
    end
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      if (send_val_o[s] !== 1'b1 || recv_rdy_o[s] !== 1'b0) begin
        failures++;
        $display("FAIL issue_latency stage%0d send_val=%b recv_rdy=%b expected send_val=1 recv_rdy=0",
                 s, send_val_o[s], recv_rdy_o[s]);
      end
    end
  endtask

  task automatic check_front();
    pair_t got;
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      got = observed(s);
      if (exp_q[s].size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty stage%0d got=%h expected no pending pair", s, got);
      end else if (got !== exp_q[s][0]) begin
        failures++;
        $display("FAIL pair_data stage%0d got=%h expected=%h", s, got, exp_q[s][0]);
      end
    end
  endtask

  task automatic drain(input int stall_pair, input int stall_len, input int stop_after);
    int got = 0;
    int stalls = 0;
    int t = 0;
    while (got < stop_after && t < 200) begin
      for (int s = 0; s < NDUT; s++) begin
        checks++;
        if (send_val_o[s] !== 1'b1) begin
          failures++;
          $display("FAIL send_val_issue stage%0d got=%b expected 1", s, send_val_o[s]);
        end
      end
      check_front();
      if (got == stall_pair && stalls < stall_len) begin
        send_rdy = 1'b0;
        stalls++;
      end else begin
        send_rdy = 1'b1;
        got++;
        for (int s = 0; s < NDUT; s++) void'(exp_q[s].pop_front());
      end
      @(negedge clk);
      t++;
    end
    send_rdy = 1'b0;
    checks++;
    if (t >= 200) begin
      failures++;
      $display("FAIL drain_timeout pairs=%0d expected %0d", got, stop_after);
    end
  endtask

  task automatic check_frame_done(input string name);
    check_idle(name);
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      if (exp_q[s].size() != 0) begin
        failures++;
        $display("FAIL %s_leftover stage%0d pending=%0d expected 0", name, s, exp_q[s].size());
      end
    end
  endtask

  task automatic test_reset();
    pair_t got;
    pair_t zero_pair;
    zero_pair = '{ar: 32'h0, ac: 32'h0, br: 32'h0, bc: 32'h0, wr: 32'h100, wc: 32'h200};
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      got = observed(s);
      if (got !== zero_pair) begin
        failures++;
        $display("FAIL reset_outputs stage%0d got=%h expected=%h", s, got, zero_pair);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
  endtask

  task automatic test_stages();
    load_frame(0, 0);
    drain(-1, 0, NP);
    check_frame_done("stages");
  endtask

  task automatic test_backpressure();
    load_frame(10, 1);
    drain(1, 3, NP);
    check_frame_done("backpressure");
  endtask

  task automatic test_reset_mid_issue();
    load_frame(50, 0);
    drain(-1, 0, 2);
    #2 reset = 1'b0;
    #1;
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      if (send_val_o[s] !== 1'b0 || recv_rdy_o[s] !== 1'b1 || ar_o[s] !== 32'h0) begin
        failures++;
        $display("FAIL async_reset stage%0d send_val=%b recv_rdy=%b ar=%h expected 0,1,00000000",
                 s, send_val_o[s], recv_rdy_o[s], ar_o[s]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < NDUT; s++) exp_q[s].delete();
    @(negedge clk);
    load_frame(200, 0);
    drain(-1, 0, NP);
    check_frame_done("after_reset");
  endtask

  task automatic test_back_to_back();
    load_frame(0, 0);
    drain(-1, 0, NP);
    check_frame_done("b2b_first");
    load_frame(100, 0);
    drain(-1, 0, NP);
    check_frame_done("b2b_second");
  endtask

  initial begin
    for (int j = 0; j < NP; j++) begin
      wr_table[j*n +: n] = 32'h100 + 32'(j);
      wc_table[j*n +: n] = 32'h200 + 32'(j);
    end
    test_reset();
    test_stages();
    test_backpressure();
    test_reset_mid_issue();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
